// File: rtl/sine_period_meter.sv
// sine_period_meter
// Measures the period, in samples, of an 8-bit offset-binary tone. A rising
// mid-scale crossing is detected with a Schmitt level (thresholds MID+/-HYST).
// The period between consecutive crossings is reported on period_out with a
// one-cycle period_valid strobe. locked shows that consecutive periods agree
// within TOL. overflow is sticky and shows that a period exceeded 2^PW-1 samples.
// Optional build macro PERIOD_AVG_EN reports a sliding 4-period average
// instead of the raw period.
module sine_period_meter #(
  parameter int DATA_W = 8,
  parameter int PW     = 12,
  parameter int MID    = 128,
  parameter int HYST   = 8,
  parameter int TOL    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [PW-1:0]     period_out,
  output logic              period_valid,
  output logic              locked,
  output logic              overflow
);

  localparam logic [DATA_W-1:0] TH_H    = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] TH_L    = DATA_W'(MID - HYST);
  localparam logic [PW-1:0]     CNT_MAX = {PW{1'b1}};
  localparam logic [PW:0]       TOL_W   = (PW+1)'(TOL);

  typedef enum logic [1:0] {SEARCH, ARM, FIRST, MEASURE} state_t;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v == CNT_MAX) ? v : v + PW'(1);
  endfunction

  function automatic logic [PW:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic signed [PW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  state_t        state, state_nxt;
  logic          hi, hi_lvl_p0, hi_nxt, edge_p0;
  logic [PW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] prev_period, prev_nxt;
  logic          report_p0, lock_nxt, ovf_nxt;
  logic [PW-1:0] period_nxt;
  logic          pv_nxt;
  logic [PW-1:0] period_p1;
  logic          vld_p1;

  assign period_out   = period_p1;
  assign period_valid = vld_p1;

  // Stage p0: Schmitt level from the incoming sample and rising-edge detect
  always_comb begin
    hi_lvl_p0 = hi;
    if (sample >= TH_H)
      hi_lvl_p0 = 1'b1;
    else if (sample <= TH_L)
      hi_lvl_p0 = 1'b0;
    hi_nxt  = sample_valid ? hi_lvl_p0 : hi;
    edge_p0 = sample_valid & hi_lvl_p0 & ~hi;
  end

  // Stage p0: measurement FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  // Stage p0: next state, counter and lock decisions; nothing moves without a valid sample
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prev_nxt  = prev_period;
    report_p0 = 1'b0;
    lock_nxt  = locked;
    ovf_nxt   = overflow;
    if (sample_valid) begin
      case (state)
        SEARCH: begin
          // a capture that starts in the high half must see the low half first
          if (!hi_lvl_p0)
            state_nxt = ARM;
        end
        ARM: begin
          if (edge_p0) begin
            cnt_nxt   = PW'(1);
            state_nxt = FIRST;
          end
        end
        FIRST, MEASURE: begin
          if (edge_p0) begin
            report_p0 = 1'b1;
            prev_nxt  = cnt;
            cnt_nxt   = PW'(1);
            state_nxt = MEASURE;
            if (state == MEASURE)
              lock_nxt = (abs_diff(cnt, prev_period) <= TOL_W);
          end else if (cnt == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            lock_nxt  = 1'b0;
            state_nxt = ARM;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

`ifdef PERIOD_AVG_EN
  logic [PW-1:0] hist [4];
  logic [PW+1:0] sum, sum_nxt;
  logic [2:0]    n_hist;
  logic          clr_hist_p0;

  // leaving FIRST/MEASURE for ARM only happens on overflow
  assign clr_hist_p0 = (state_nxt == ARM) && (state != ARM);

  // Stage p0: sliding sum over the last four periods and the averaged result
  always_comb begin
    sum_nxt    = sum + {2'b00, cnt} - {2'b00, hist[3]};
    period_nxt = sum_nxt[PW+1:2];
    pv_nxt     = report_p0 && (n_hist >= 3'd3);
  end

  // Stage p1: period history, cleared on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist   <= '{default: '0};
      sum    <= '0;
      n_hist <= '0;
    end else if (clr_hist_p0) begin
      hist   <= '{default: '0};
      sum    <= '0;
      n_hist <= '0;
    end else if (report_p0) begin
      hist[0] <= cnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
      sum     <= sum_nxt;
      if (n_hist != 3'd4)
        n_hist <= n_hist + 3'd1;
    end
  end
`else
  // Stage p0: raw period straight from the counter
  always_comb begin
    period_nxt = cnt;
    pv_nxt     = report_p0;
  end
`endif

  // Stage p1: registered measurement state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi          <= 1'b0;
      cnt         <= '0;
      prev_period <= '0;
      period_p1   <= '0;
      vld_p1      <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      hi          <= hi_nxt;
      cnt         <= cnt_nxt;
      prev_period <= prev_nxt;
      locked      <= lock_nxt;
      overflow    <= ovf_nxt;
      vld_p1      <= pv_nxt;
      if (pv_nxt)
        period_p1 <= period_nxt;
    end
  end

endmodule

// File: tb/tb_sine_period_meter.sv
// Scoreboard bench for sine_period_meter: a reference model turns every
// applied sample into expected period reports; a monitor compares each
// period_valid pulse and each queued state check against the DUT.
module tb_sine_period_meter;

  localparam int PW   = 12;
  localparam int MID  = 128;
  localparam int HYST = 8;
  localparam int TOL  = 1;
  localparam int TH_H = MID + HYST;
  localparam int TH_L = MID - HYST;
  localparam int MAXP = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample = 8'd0;
  logic [PW-1:0] period_out;
  logic          period_valid;
  logic          locked;
  logic          overflow;

  always #5 clk = ~clk;

  sine_period_meter #(.DATA_W(8), .PW(PW), .MID(MID), .HYST(HYST), .TOL(TOL)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  typedef struct { int period; bit lck; bit ovf; } exp_t;
  typedef struct { string name; bit drain; bit full; int per; bit pv; bit lck; bit ovf; } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state: gaps between rising crossings, counted in valid samples
  bit m_lvl, m_ready, m_have_edge, m_have_prev, m_locked, m_ovf;
  int m_idx, m_last, m_prev;
  int m_hist[$];

  function automatic void model_reset();
    m_lvl = 0; m_ready = 0; m_have_edge = 0; m_have_prev = 0;
    m_locked = 0; m_ovf = 0; m_idx = 0; m_last = 0; m_prev = 0;
    m_hist.delete();
  endfunction

  function automatic void model_sample(int s);
    bit   lvl;
    bit   rise;
    int   p;
    int   d;
    int   acc;
    exp_t e;
    lvl = m_lvl;
    if (s >= TH_H) lvl = 1;
    else if (s <= TH_L) lvl = 0;
    rise  = lvl && !m_lvl;
    m_lvl = lvl;
    if (!m_ready) begin
      if (!lvl) m_ready = 1;
    end else if (rise) begin
      if (m_have_edge) begin
        p = m_idx - m_last;
        if (m_have_prev) begin
          d = (p > m_prev) ? p - m_prev : m_prev - p;
          m_locked = (d <= TOL);
        end
        m_prev = p;
        m_have_prev = 1;
`ifdef PERIOD_AVG_EN
        m_hist.push_back(p);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) begin
          acc = 0;
          foreach (m_hist[i]) acc += m_hist[i];
          e.period = acc / 4; e.lck = m_locked; e.ovf = m_ovf;
          exp_q.push_back(e);
        end
`else
        acc = p;
        e.period = acc; e.lck = m_locked; e.ovf = m_ovf;
        exp_q.push_back(e);
`endif
      end
      m_have_edge = 1;
      m_last = m_idx;
    end else if (m_have_edge && (m_idx - m_last) == MAXP) begin
      m_ovf = 1; m_locked = 0; m_have_edge = 0; m_have_prev = 0;
      m_hist.delete();
    end
    m_idx++;
  endfunction

  exp_t mon_e;
  chk_t mon_c;

  // monitor: pops expectations on every pulse and services queued state checks
  always @(negedge clk) begin
    if (!rst && period_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: period_out=%0d locked=%0b, no report expected", period_out, locked);
      end else begin
        mon_e = exp_q.pop_front();
        if (period_out !== PW'(mon_e.period) || locked !== mon_e.lck || overflow !== mon_e.ovf) begin
          n_err++;
          $display("FAIL pulse: got period=%0d locked=%0b ovf=%0b, want period=%0d locked=%0b ovf=%0b",
                   period_out, locked, overflow, mon_e.period, mon_e.lck, mon_e.ovf);
        end
      end
    end
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      n_vec++;
      if (mon_c.drain) begin
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL %s: %0d expected reports never appeared, want 0", mon_c.name, exp_q.size());
        end
      end else if (locked !== mon_c.lck || overflow !== mon_c.ovf || period_valid !== mon_c.pv ||
                   (mon_c.full && period_out !== PW'(mon_c.per))) begin
        n_err++;
        $display("FAIL %s: got period=%0d pv=%0b locked=%0b ovf=%0b, want period=%0d pv=%0b locked=%0b ovf=%0b",
                 mon_c.name, period_out, period_valid, locked, overflow,
                 mon_c.per, mon_c.pv, mon_c.lck, mon_c.ovf);
      end
    end
  end

  task automatic expect_state(input string nm, input bit full, input int per, input bit lck, input bit ovf);
    chk_t c;
    c.name = nm; c.drain = 0; c.full = full; c.per = per; c.pv = 0; c.lck = lck; c.ovf = ovf;
    chk_q.push_back(c);
  endtask

  task automatic expect_drain(input string nm);
    chk_t c;
    c.name = nm; c.drain = 1; c.full = 0; c.per = 0; c.pv = 0; c.lck = 0; c.ovf = 0;
    chk_q.push_back(c);
  endtask

  task automatic step(input bit v, input int s);
    sample_valid = v;
    sample = 8'(s);
    if (v) model_sample(s);
    @(posedge clk);
    #1;
  endtask

  // reset is held with a valid high sample present to show reset dominates it
  task automatic do_reset();
    step(0, 0);
    step(0, 0);
    expect_drain("drain_before_reset");
    rst = 1'b1;
    sample_valid = 1'b1;
    sample = 8'd200;
    model_reset();
    expect_state("reset_values", 1, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_valid = 1'b0;
  endtask

  function automatic int sine_s(int k, int n);
    return int'(128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(n)));
  endfunction

  task automatic rnd_step(input bit high);
    int s;
    if ($urandom_range(0, 3) == 0) step(0, int'($urandom_range(0, 255)));
    s = high ? int'($urandom_range(TH_H, 255)) : int'($urandom_range(0, TH_L));
    if ($urandom_range(0, 9) == 0) s = int'($urandom_range(TH_L + 1, TH_H - 1));
    step(1, s);
  endtask

  initial begin
    int lo_len;
    int hi_len;
    model_reset();
    do_reset();

    // DDS loopback, 128-sample sine, continuous samples
    for (int k = 0; k < 128 * 4 + 10; k++) step(1, sine_s(k, 128));
    step(0, 0);
    expect_state("sine128_end", 1, 128, 1, 0);

    // square wave 20 low / 20 high
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 20; i++) step(1, 40);
      for (int i = 0; i < 20; i++) step(1, 216);
    end
    step(0, 0);
    expect_state("square40_end", 1, 40, 1, 0);

    // 64-sample tone with sample_valid toggling every cycle
    do_reset();
    for (int k = 0; k < 64 * 5 + 5; k++) begin
      step(1, sine_s(k, 64));
      step(0, 255);
    end
    step(0, 0);
    expect_state("gapped64_end", 1, 64, 1, 0);

    // in-band noise only: no edges at all
    do_reset();
    for (int i = 0; i < 1000; i++) step(1, (i % 2) ? 131 : 125);
    step(0, 0);
    expect_state("noise_end", 1, 0, 0, 0);

    // random square-ish waves, random gaps and in-band glitches
    do_reset();
    lo_len = 20;
    hi_len = 20;
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 3))
        0: begin lo_len = int'($urandom_range(3, 40)); hi_len = int'($urandom_range(3, 40)); end
        1: hi_len = (hi_len < 50) ? hi_len + 1 : 20;
        2: hi_len = (hi_len < 50) ? hi_len + 2 : 20;
        default: ;
      endcase
      for (int i = 0; i < lo_len; i++) rnd_step(0);
      for (int i = 0; i < hi_len; i++) rnd_step(1);
    end
    step(0, 0);
    expect_state("random_end", 0, 0, m_locked, m_ovf);

    // reset in the middle of a period, then resume the tone
    do_reset();
    for (int k = 0; k < 128 * 2 + 64; k++) step(1, sine_s(k, 128));
    do_reset();
    for (int k = 320; k < 320 + 128 * 4; k++) step(1, sine_s(k, 128));
    step(0, 0);
    expect_state("rst_resume_end", 1, 128, 1, 0);

    // lock on a square wave, then hold the level high until the counter saturates
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) step(1, 40);
      for (int i = 0; i < 20; i++) step(1, 200);
    end
    step(0, 0);
    expect_state("pre_overflow_lock", 1, 40, 1, 0);
    for (int i = 0; i < MAXP; i++) step(1, 200);
    step(0, 0);
    expect_state("overflow_set", 1, 40, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 200);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) step(1, 40);
      for (int i = 0; i < 20; i++) step(1, 200);
    end
    step(0, 0);
    expect_state("overflow_sticky", 1, 40, 1, 1);
    do_reset();

    expect_drain("drain_final");
    step(0, 0);
    step(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
